uart_rx_ctrl: RTL

Receive-side sequencer for the UART block. It oversamples the serial line at 16x baud and steps the receive datapath through start validation, data shifting, parity and stop checks. It presents each completed byte with its error flags on a valid/ready handshake to the host side. It sits between the serial pin and the receive FIFO/consumer and replaces ad-hoc per-bit shift/check load signals with one timed controller.

---
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive sequencer presenting bytes and error flags on valid/ready
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 pb_error,
    output logic                 sb_error,
    output logic                 overrun,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic                 rx_m, rx_s;
    logic                 armed, p_en, p_odd, pe, stop_s, done;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    assign busy = (state != IDLE);

    // two-flop synchronizer for the asynchronous serial line, idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    // frame sequencer: start validation at mid start bit, then one sample per bit period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            armed    <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            p_en     <= 1'b0;
            p_odd    <= 1'b0;
            pe       <= 1'b0;
            stop_s   <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state    <= START;
                        armed    <= 1'b0;
                        tick_cnt <= '0;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == MID) begin
                            state    <= rx_s ? IDLE : DATA;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            p_en     <= parity_en;
                            p_odd    <= parity_odd;
                            pe       <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == LAST) begin
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT)
                                state <= p_en ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == LAST) begin
                            pe    <= ((^shreg) ^ rx_s) != p_odd;
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == LAST) begin
                            stop_s <= rx_s;
                            done   <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // output holding register: load on frame completion, clear flags on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            pb_error <= 1'b0;
            sb_error <= 1'b0;
            overrun  <= 1'b0;
        end else if (done) begin
            rx_data  <= shreg;
            pb_error <= pe;
            sb_error <= ~stop_s;
            rx_valid <= 1'b1;
            overrun  <= rx_valid && !rx_ready;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            pb_error <= 1'b0;
            sb_error <= 1'b0;
            overrun  <= 1'b0;
        end
    end
endmodule
